// File: rtl/bnn_pkg.sv
// bnn_pkg: shared constants and types for the BNN classifier and its input stage.
// No ports. Holds image geometry, class count, the packed image vector type and the
// frame packer state type.
package bnn_pkg;

  localparam int unsigned N_PIX   = 784;
  localparam int unsigned IMG_DIM = 28;
  localparam int unsigned N_CLASS = 10;
  localparam int unsigned LABEL_W = 4;

  typedef logic [N_PIX-1:0] img_vec_t;

  typedef enum logic {COLLECT, DISCARD} pack_state_t;

endpackage

// File: rtl/mnist_frame_packer_if.sv
// mnist_frame_packer_if: pixel-stream input and packed-frame output of the frame packer.
// Signals:
//   i_valid, i_pixels, i_last   raw pixel beats toward the packer
//   o_valid, o_data, o_err      packed frame / frame-length error pulses from the packer
//   o_frame_cnt                 good-frame counter
// Modports: master = stream source / frame consumer, slave = the packer.
interface mnist_frame_packer_if #(
  parameter int unsigned N_PIX        = bnn_pkg::N_PIX,
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned PIX_PER_BEAT = 8
);

  logic                          i_valid;
  logic [PIX_PER_BEAT*PIX_W-1:0] i_pixels;
  logic                          i_last;
  logic                          o_valid;
  logic [N_PIX-1:0]              o_data;
  logic                          o_err;
  logic [15:0]                   o_frame_cnt;

  modport master (
    output i_valid, i_pixels, i_last,
    input  o_valid, o_data, o_err, o_frame_cnt
  );

  modport slave (
    input  i_valid, i_pixels, i_last,
    output o_valid, o_data, o_err, o_frame_cnt
  );

endinterface

// File: rtl/pixel_binarizer.sv
// pixel_binarizer: purely combinational per-lane threshold.
// Ports:
//   pixels  in   PIX_PER_BEAT*PIX_W   lane k = pixels[k*PIX_W +: PIX_W]
//   bits    out  PIX_PER_BEAT         bits[k] = (lane k >= THRESH), unsigned compare
module pixel_binarizer #(
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned PIX_PER_BEAT = 8,
  parameter int unsigned THRESH       = 128
) (
  input  logic [PIX_PER_BEAT*PIX_W-1:0] pixels,
  output logic [PIX_PER_BEAT-1:0]       bits
);

  // Compare at 32 bits so THRESH above the pixel range yields all zeros.
  always_comb begin
    bits = '0;
    for (int k = 0; k < int'(PIX_PER_BEAT); k++) begin
      bits[k] = (32'(pixels[k*PIX_W +: PIX_W]) >= THRESH);
    end
  end

endmodule

// File: rtl/mnist_frame_packer.sv
// mnist_frame_packer: binarizes a raw pixel stream and packs one image into a single frame
// vector, checking frame length against i_last.
// Ports:
//   clk     in  clock, rising edge
//   rst_n   in  asynchronous active-low reset
//   bus     slave modport of mnist_frame_packer_if:
//             i_valid/i_pixels/i_last  input beats (no backpressure)
//             o_valid  one-cycle pulse, o_data holds a good frame (pixel 0 at the MSB)
//             o_err    one-cycle pulse on a short or overlong frame
//             o_frame_cnt  good frames emitted, wraps at 16 bits
module mnist_frame_packer #(
  parameter int unsigned N_PIX        = bnn_pkg::N_PIX,
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned PIX_PER_BEAT = 8,
  parameter int unsigned THRESH       = 128
) (
  input logic                 clk,
  input logic                 rst_n,
  mnist_frame_packer_if.slave bus
);

  import bnn_pkg::*;

  localparam int unsigned BEATS = N_PIX / PIX_PER_BEAT;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if ((N_PIX % PIX_PER_BEAT) != 0) begin : g_bad_cfg
    $error("mnist_frame_packer: N_PIX must be a multiple of PIX_PER_BEAT");
  end

  pack_state_t        state_q, state_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [N_PIX-1:0]   data_q;
  logic [N_PIX-1:0]   frame_now;
  logic               load;
  logic [PIX_PER_BEAT-1:0] beat_bits;
  logic [PIX_PER_BEAT-1:0] slot_bits;

  pixel_binarizer #(
    .PIX_W       (PIX_W),
    .PIX_PER_BEAT(PIX_PER_BEAT),
    .THRESH      (THRESH)
  ) u_binarizer (
    .pixels(bus.i_pixels),
    .bits  (beat_bits)
  );

  // Lane 0 is the lowest pixel index, which sits at the high end of its slot.
  always_comb begin
    slot_bits = '0;
    for (int k = 0; k < int'(PIX_PER_BEAT); k++) begin
      slot_bits[PIX_PER_BEAT-1-k] = beat_bits[k];
    end
  end

  // Assembly register, one slot per beat. frame_now forwards the beat being written so the
  // final beat lands in the output register on the same edge.
  for (genvar b = 0; b < int'(BEATS); b++) begin : g_slot
    localparam int unsigned HI = N_PIX - 1 - b * PIX_PER_BEAT;
    logic                    we;
    logic [PIX_PER_BEAT-1:0] slot_q;

    assign we = (state_q == COLLECT) && bus.i_valid && (beat_q == CNT_W'(b));

    always_ff @(posedge clk) begin
      if (we) slot_q <= slot_bits;
    end

    assign frame_now[HI -: PIX_PER_BEAT] = we ? slot_bits : slot_q;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (bus.i_valid) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (bus.i_last) begin
              valid_d = 1'b1;
              load    = 1'b1;
              cnt_d   = cnt_q + 16'd1;
            end else begin
              err_d   = 1'b1;
              state_d = DISCARD;
            end
          end else if (bus.i_last) begin
            err_d  = 1'b1;
            beat_d = '0;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      DISCARD: begin
        if (bus.i_valid && bus.i_last) begin
          state_d = COLLECT;
          beat_d  = '0;
        end
      end
      default: begin
        state_d = COLLECT;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      beat_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (load) data_q <= frame_now;
    end
  end

  assign bus.o_valid     = valid_q;
  assign bus.o_err       = err_q;
  assign bus.o_data      = data_q;
  assign bus.o_frame_cnt = cnt_q;

endmodule
